can_bus_master: RTL and testbench

Queued, parametrised bus master for an SJA1000-style CAN controller on a multiplexed Intel-mode address/data bus (ALE, CS#, RD#, WR#, AD). It accepts read/write commands from user logic into a command FIFO and executes them back-to-back with programmable phase widths. Read results are returned with their address. It replaces the single-shot, fixed-timing CAN send driver as the CAN controller front end in the FPGA bus-driver layer.

---
 rtl/can_bus_master.sv | 272 +++++++++++++++++++++++++++
 tb/tb_can_bus_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_bus_master.sv
// Queued command front end for an SJA1000-style CAN controller on a multiplexed Intel-mode bus.
// Commands are buffered in a small FIFO and replayed with programmable ALE/hold/strobe/recover widths.
module can_bus_master #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned T_ALE      = 2,
    parameter int unsigned T_AHOLD    = 1,
    parameter int unsigned T_STROBE   = 4,
    parameter int unsigned T_RECOVER  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic [1:0]        i_can_wr_sel,
    input  logic [ADDR_W-1:0] i_can_wr_addr,
    input  logic [DATA_W-1:0] i_can_data,
    input  logic              i_can_data_valid,
    output logic              o_can_ready,
    output logic              o_can_overflow,
    output logic              o_can_cmd_err,
    output logic              o_can_busy,
    output logic [ADDR_W-1:0] o_can_addr,
    output logic [DATA_W-1:0] o_can_data,
    output logic              o_can_data_valid,
    output logic              can_ale,
    output logic              can_cs,
    output logic              can_rd,
    output logic              can_wr,
    inout  wire  [DATA_W-1:0] can_ad
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

    localparam int unsigned TMax01 = (T_ALE > T_AHOLD) ? T_ALE : T_AHOLD;
    localparam int unsigned TMax23 = (T_STROBE > T_RECOVER) ? T_STROBE : T_RECOVER;
    localparam int unsigned TMax   = (TMax01 > TMax23) ? TMax01 : TMax23;
    localparam int unsigned TW     = (TMax > 1) ? $clog2(TMax) : 1;

    localparam logic [TW-1:0] LdAle     = TW'(T_ALE - 1);
    localparam logic [TW-1:0] LdAhold   = TW'(T_AHOLD - 1);
    localparam logic [TW-1:0] LdStrobe  = TW'(T_STROBE - 1);
    localparam logic [TW-1:0] LdRecover = TW'(T_RECOVER - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAle,
        StAhold,
        StStrobe,
        StRecover
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO: entry = {is_read, addr, data}
    // ------------------------------------------------------------------
    logic [EntW-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            avail_q;
    logic            fifo_full, fifo_empty;
    logic            sel_ok, push, pop;
    logic            overflow_q, overflow_d;
    logic            cmd_err_q, cmd_err_d;

    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign sel_ok     = (i_can_wr_sel == 2'b01) || (i_can_wr_sel == 2'b10);
    assign push       = i_can_data_valid && sel_ok && !fifo_full;
    assign overflow_d = i_can_data_valid && sel_ok && fifo_full;
    assign cmd_err_d  = i_can_data_valid && !sel_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {i_can_wr_sel == 2'b10, i_can_wr_addr, i_can_data};
        end
    end

    // avail_q lags the level by a cycle so an idle bus starts two edges after acceptance
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            avail_q    <= 1'b0;
            overflow_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            avail_q    <= !fifo_empty;
            overflow_q <= overflow_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus sequencer
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            phase_last;
    logic            cmd_read_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_data_q;
    logic [EntW-1:0] head;
    logic            capture;

    assign phase_last = (cnt_q == '0);
    assign head       = fifo_mem_q[rd_ptr_q];
    assign capture    = (state_q == StStrobe) && phase_last && cmd_read_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (avail_q && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StAle;
                    cnt_d   = LdAle;
                end
            end
            StAle: begin
                if (phase_last) begin
                    state_d = StAhold;
                    cnt_d   = LdAhold;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            StAhold: begin
                if (phase_last) begin
                    state_d = StStrobe;
                    cnt_d   = LdStrobe;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            StStrobe: begin
                if (phase_last) begin
                    state_d = StRecover;
                    cnt_d   = LdRecover;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            StRecover: begin
                if (phase_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StAle;
                        cnt_d   = LdAle;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cmd_read_q <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                {cmd_read_q, cmd_addr_q, cmd_data_q} <= head;
            end
        end
    end

    // Read results are registered at the last strobe edge, so they appear in the first RECOVER cycle
    logic [ADDR_W-1:0] raddr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            raddr_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= capture;
            if (capture) begin
                raddr_q <= cmd_addr_q;
                rdata_q <= can_ad;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus pins, decoded straight from state so reset releases them asynchronously
    // ------------------------------------------------------------------
    logic              ad_oe;
    logic [DATA_W-1:0] ad_out;

    always_comb begin
        can_ale = 1'b0;
        can_cs  = 1'b1;
        can_rd  = 1'b1;
        can_wr  = 1'b1;
        ad_oe   = 1'b0;
        ad_out  = cmd_data_q;
        unique case (state_q)
            StAle: begin
                can_cs  = 1'b0;
                can_ale = 1'b1;
                ad_oe   = 1'b1;
                ad_out  = DATA_W'(cmd_addr_q);
            end
            StAhold: begin
                can_cs = 1'b0;
                ad_oe  = 1'b1;
                ad_out = DATA_W'(cmd_addr_q);
            end
            StStrobe: begin
                can_cs = 1'b0;
                if (cmd_read_q) begin
                    can_rd = 1'b0;
                end else begin
                    can_wr = 1'b0;
                    ad_oe  = 1'b1;
                end
            end
            StRecover: begin
                // write data is held one extra cycle past WR# rising for the controller's hold time
                ad_oe = !cmd_read_q && (cnt_q == LdRecover);
            end
            default: ;
        endcase
    end

    assign can_ad = ad_oe ? ad_out : 'z;

    assign o_can_ready      = !fifo_full;
    assign o_can_overflow   = overflow_q;
    assign o_can_cmd_err    = cmd_err_q;
    assign o_can_busy       = (state_q != StIdle) || !fifo_empty;
    assign o_can_addr       = raddr_q;
    assign o_can_data       = rdata_q;
    assign o_can_data_valid = rvalid_q;

endmodule

// File: tb/tb_can_bus_master.sv
// Directed bench for can_bus_master: bus phase timing, read return, queueing, drops and reset.
module tb_can_bus_master;

    logic       sys_clk = 1'b0;
    logic       sys_reset_n;
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] data;
    logic       valid;
    logic       ready, overflow, cmd_err, busy;
    logic [7:0] o_addr, o_data;
    logic       o_valid;
    logic       can_ale, can_cs, can_rd, can_wr;
    wire  [7:0] can_ad;
    logic       drv_en;
    logic [7:0] drv;

    assign can_ad = drv_en ? drv : 8'hzz;

    can_bus_master dut (
        .sys_clk          (sys_clk),
        .sys_reset_n      (sys_reset_n),
        .i_can_wr_sel     (sel),
        .i_can_wr_addr    (addr),
        .i_can_data       (data),
        .i_can_data_valid (valid),
        .o_can_ready      (ready),
        .o_can_overflow   (overflow),
        .o_can_cmd_err    (cmd_err),
        .o_can_busy       (busy),
        .o_can_addr       (o_addr),
        .o_can_data       (o_data),
        .o_can_data_valid (o_valid),
        .can_ale          (can_ale),
        .can_cs           (can_cs),
        .can_rd           (can_rd),
        .can_wr           (can_wr),
        .can_ad           (can_ad)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ale_rises = 0, wr_low = 0, cs_low = 0, dv_cnt = 0, ovf_cnt = 0, err_cnt = 0, viol = 0;
    logic ale_prev = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        ale_prev <= can_ale;
        if (can_ale && !ale_prev) ale_rises <= ale_rises + 1;
        if (!can_wr) wr_low <= wr_low + 1;
        if (!can_cs) cs_low <= cs_low + 1;
        if (o_valid) dv_cnt <= dv_cnt + 1;
        if (overflow) ovf_cnt <= ovf_cnt + 1;
        if (cmd_err) err_cnt <= err_cnt + 1;
        if ((!can_rd && !can_wr) || (can_ale && (!can_rd || !can_wr))) viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic push(input logic [1:0] s, input logic [7:0] a, input logic [7:0] d);
        sel   = s;
        addr  = a;
        data  = d;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    // Called at the negedge of the first ALE cycle; walks all 9 cycles of one transaction.
    task automatic run_txn(input string tag, input bit rd, input logic [7:0] a,
                           input logic [7:0] d);
        for (int i = 0; i < 9; i++) begin
            logic [3:0] exp_bus;
            logic [7:0] exp_ad;
            logic       exp_dv;
            if (rd && i >= 3 && i <= 6) begin
                drv_en = 1'b1;
                drv    = d;
            end else if (i == 8 || (rd && i == 7)) begin
                drv_en = 1'b1;
                drv    = 8'h00;
            end else begin
                drv_en = 1'b0;
            end
            #1;
            if (i < 2) begin
                exp_bus = 4'b1011;
                exp_ad  = a;
            end else if (i == 2) begin
                exp_bus = 4'b0011;
                exp_ad  = a;
            end else if (i <= 6) begin
                exp_bus = rd ? 4'b0001 : 4'b0010;
                exp_ad  = d;
            end else begin
                exp_bus = 4'b0111;
                exp_ad  = (i == 7 && !rd) ? d : 8'h00;
            end
            exp_dv = rd && (i == 7);
            check($sformatf("%s.bus%0d", tag, i), {can_ale, can_cs, can_rd, can_wr}, exp_bus);
            check($sformatf("%s.ad%0d", tag, i), can_ad, exp_ad);
            check($sformatf("%s.dv%0d", tag, i), o_valid, exp_dv);
            if (exp_dv) begin
                check($sformatf("%s.raddr", tag), o_addr, a);
                check($sformatf("%s.rdata", tag), o_data, d);
            end
            step();
        end
        drv_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c_start, r0, w0, s0, o0, e0, d0, n, lvl;
        bit exp_drop;

        sys_reset_n = 1'b0;
        valid = 1'b0;
        sel   = 2'b00;
        addr  = 8'h00;
        data  = 8'h00;
        drv_en = 1'b0;
        drv   = 8'h00;
        repeat (2) @(negedge sys_clk);

        // Reset state
        check("rst.bus", {can_ale, can_cs, can_rd, can_wr}, 4'b0111);
        check("rst.ready", ready, 1'b1);
        check("rst.busy", busy, 1'b0);
        check("rst.pulses", {o_valid, overflow, cmd_err}, 3'b000);
        check("rst.oaddr", o_addr, 8'h00);
        check("rst.odata", o_data, 8'h00);
        drv_en = 1'b1;
        #1 check("rst.ad_released", can_ad, 8'h00);
        drv_en = 1'b0;
        sys_reset_n = 1'b1;
        step();

        // Single write, with acceptance-to-ALE latency
        push(2'b01, 8'h01, 8'h5A);
        check("wr1.busy_e1", busy, 1'b1);
        check("wr1.bus_e1", {can_ale, can_cs, can_rd, can_wr}, 4'b0111);
        step();
        check("wr1.bus_e2", {can_ale, can_cs, can_rd, can_wr}, 4'b0111);
        step();
        run_txn("wr1", 1'b0, 8'h01, 8'h5A);
        check("wr1.busy_end", busy, 1'b0);
        check("wr1.bus_end", {can_ale, can_cs, can_rd, can_wr}, 4'b0111);

        // Reads with bench-driven data
        push(2'b10, 8'h01, 8'h00);
        step();
        step();
        run_txn("rd1", 1'b1, 8'h01, 8'hA5);
        push(2'b10, 8'h12, 8'h00);
        step();
        step();
        run_txn("rd2", 1'b1, 8'h12, 8'h4C);
        check("rd2.busy_end", busy, 1'b0);

        // Four writes back-to-back: 2 cycles latency + 36 bus cycles, no gaps
        c_start = cyc;
        r0 = ale_rises;
        w0 = wr_low;
        s0 = cs_low;
        for (int k = 0; k < 4; k++) begin
            sel   = 2'b01;
            addr  = 8'(8'h50 + k);
            data  = 8'(8'hA0 + k);
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check("burst.len", cyc - c_start, 39);
        check("burst.ale_rises", ale_rises - r0, 4);
        check("burst.wr_low", wr_low - w0, 16);
        check("burst.cs_low", cs_low - s0, 28);

        // Overflow: one in flight, then six valid pushes and one invalid-while-full
        r0 = ale_rises;
        w0 = wr_low;
        o0 = ovf_cnt;
        e0 = err_cnt;
        push(2'b01, 8'h30, 8'h11);
        step();
        step();
        lvl = 0;
        for (int k = 0; k < 7; k++) begin
            sel   = (k == 6) ? 2'b11 : 2'b01;
            addr  = 8'(8'h40 + k);
            data  = 8'(8'h60 + k);
            valid = 1'b1;
            step();
            if (k < 6) begin
                exp_drop = (lvl == 4);
                if (!exp_drop) lvl++;
                check($sformatf("ovf.pulse%0d", k), overflow, exp_drop);
                check($sformatf("ovf.err%0d", k), cmd_err, 1'b0);
            end else begin
                check("ovf.full_err", cmd_err, 1'b1);
                check("ovf.full_noovf", overflow, 1'b0);
            end
            check($sformatf("ovf.ready%0d", k), ready, lvl < 4);
        end
        valid = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        check("ovf.executed", ale_rises - r0, 5);
        check("ovf.wr_low", wr_low - w0, 20);
        check("ovf.dropped", ovf_cnt - o0, 2);
        check("ovf.err_cnt", err_cnt - e0, 1);

        // Invalid selects on an idle bus
        r0 = ale_rises;
        e0 = err_cnt;
        sel   = 2'b00;
        addr  = 8'h07;
        data  = 8'h01;
        valid = 1'b1;
        step();
        check("inv00.err", cmd_err, 1'b1);
        check("inv00.ovf", overflow, 1'b0);
        check("inv00.busy", busy, 1'b0);
        sel = 2'b11;
        step();
        check("inv11.err", cmd_err, 1'b1);
        check("inv11.busy", busy, 1'b0);
        check("inv11.ready", ready, 1'b1);
        valid = 1'b0;
        step();
        check("inv.err_clear", cmd_err, 1'b0);
        repeat (4) step();
        check("inv.no_bus", ale_rises - r0, 0);
        check("inv.err_cnt", err_cnt - e0, 2);

        // Reset during the strobe of a read
        d0 = dv_cnt;
        push(2'b10, 8'h12, 8'h00);
        step();
        step();
        repeat (4) step();
        drv_en = 1'b1;
        drv    = 8'h4C;
        #1 check("mrst.pre_bus", {can_ale, can_cs, can_rd, can_wr}, 4'b0001);
        sys_reset_n = 1'b0;
        #1 check("mrst.bus", {can_ale, can_cs, can_rd, can_wr}, 4'b0111);
        drv = 8'h00;
        #1 check("mrst.ad_released", can_ad, 8'h00);
        check("mrst.busy", busy, 1'b0);
        check("mrst.ready", ready, 1'b1);
        check("mrst.odata", o_data, 8'h00);
        check("mrst.oaddr", o_addr, 8'h00);
        repeat (3) step();
        drv_en = 1'b0;
        sys_reset_n = 1'b1;
        step();
        check("mrst.no_dv", dv_cnt - d0, 0);
        check("mrst.idle_bus", {can_ale, can_cs, can_rd, can_wr}, 4'b0111);
        push(2'b01, 8'h22, 8'h99);
        step();
        step();
        run_txn("postrst", 1'b0, 8'h22, 8'h99);
        check("postrst.busy", busy, 1'b0);

        check("protocol.violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
